// File: rtl/data_memory_if.sv
// Load/store bus between the datapath and data_memory.
// The master drives address/data/control; the slave returns load data and error status.
interface data_memory_if;
   logic [31:0] address;
   logic [31:0] writeData;
   logic        memRead;
   logic        memWrite;
   logic [2:0]  funct3;
   logic [31:0] readData;
   logic        misaligned;
   logic        errorSticky;

   modport master (
      output address, writeData, memRead, memWrite, funct3,
      input  readData, misaligned, errorSticky
   );

   modport slave (
      input  address, writeData, memRead, memWrite, funct3,
      output readData, misaligned, errorSticky
   );
endinterface

// File: rtl/data_memory.sv
// Byte-addressable RISC-V data memory: combinational loads, clocked stores, B/H/W with extension.
// DMEM_MISALIGN_TRAP_EN: block misaligned accesses and flag them; otherwise force-align silently.
module data_memory #(
   parameter int unsigned DEPTH = 256
) (
   input logic         clock,
   input logic         reset,
   data_memory_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [31:0]   mem_q [DEPTH];
   logic          error_q, error_d;
   logic [AW-1:0] idx;
   logic [31:0]   word;
   logic [31:0]   shifted;
   logic [31:0]   rdata;
   logic [31:0]   wdata;
   logic [3:0]    be;
   logic [1:0]    off;
   logic          access;
   logic          illegal;
   logic          trap_block;
   logic          mis_out;
   logic          unused_addr;

   assign idx         = bus.address[AW+1:2];
   assign unused_addr = ^bus.address[31:AW+2];
   assign word        = mem_q[idx];
   assign access      = bus.memRead | bus.memWrite;
   assign illegal     = (bus.funct3 == 3'b011) | (bus.funct3 == 3'b110) | (bus.funct3 == 3'b111);

`ifdef DMEM_MISALIGN_TRAP_EN
   logic is_half, is_word, mis_raw;
   assign is_half    = (bus.funct3 == 3'b001) | (bus.funct3 == 3'b101);
   assign is_word    = (bus.funct3 == 3'b010);
   assign mis_raw    = (is_half & bus.address[0]) | (is_word & (|bus.address[1:0]));
   assign trap_block = mis_raw;
   assign mis_out    = reset & access & mis_raw;
`else
   assign trap_block = 1'b0;
   assign mis_out    = 1'b0;
`endif

   // Halfwords pick the lane pair from address[1]; words always start at lane 0.
   always_comb begin
      off = bus.address[1:0];
      case (bus.funct3[1:0])
         2'b01:   off = {bus.address[1], 1'b0};
         2'b10:   off = 2'b00;
         default: off = bus.address[1:0];
      endcase
   end

   assign shifted = word >> {off, 3'b000};

   always_comb begin
      rdata = '0;
      case (bus.funct3)
         3'b000:  rdata = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  rdata = {{16{shifted[15]}}, shifted[15:0]};
         3'b010:  rdata = word;
         3'b100:  rdata = {24'h0, shifted[7:0]};
         3'b101:  rdata = {16'h0, shifted[15:0]};
         default: rdata = '0;
      endcase
   end

   always_comb begin
      be    = 4'b0000;
      wdata = bus.writeData;
      case (bus.funct3)
         3'b000: begin
            be    = 4'b0001 << off;
            wdata = {4{bus.writeData[7:0]}};
         end
         3'b001: begin
            be    = 4'b0011 << off;
            wdata = {2{bus.writeData[15:0]}};
         end
         3'b010:  be = 4'b1111;
         default: be = 4'b0000;
      endcase
      if (!bus.memWrite || trap_block) begin
         be = 4'b0000;
      end
   end

   assign error_d = error_q | mis_out | (access & illegal);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end

   assign bus.readData    = (reset & bus.memRead & !trap_block) ? rdata : 32'h0;
   assign bus.misaligned  = mis_out;
   assign bus.errorSticky = error_q;
endmodule
